// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// mult/div FSM encoding, the hard-wired zero register and default unit latencies.
package hazard_stall_ctrl_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_ZERO     = 5'd0;
    localparam int         DEF_MULT_CYC = 5;
    localparam int         DEF_DIV_CYC  = 10;
    localparam int         DEF_CNT_W    = 4;

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_timer.sv
// Tracks the HI/LO occupancy window of the multi-cycle mult/div unit:
// md_busy stays high for exactly MULT_CYC or DIV_CYC cycles after the launch cycle.
module md_busy_timer
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYC = DEF_MULT_CYC,
    parameter int DIV_CYC  = DEF_DIV_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic md_busy
);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter is loaded with N-1 so the BUSY state spans N cycles including the cnt==0 one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_BUSY;
                    cnt_d   = is_div ? CNT_W'(DIV_CYC - 1) : CNT_W'(MULT_CYC - 1);
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) state_d = MD_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign md_busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline control for the 5-stage core: PC enable, IF/ID enable/flush and ID/EX bubble
// from load-use, early-branch and HI/LO hazards, plus a saturating stall-cycle counter.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYC = DEF_MULT_CYC,
    parameter int DIV_CYC  = DEF_DIV_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_early_rs,
    input  logic        id_early_rt,
    input  logic        id_hilo_use,
    input  logic        id_br_taken,
    input  logic [4:0]  ex_rd,
    input  logic        ex_wr,
    input  logic        ex_memrd,
    input  logic        ex_md_start,
    input  logic        ex_md_is_div,
    input  logic [4:0]  mem_rd,
    input  logic        mem_memrd,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic rs_ex, rt_ex, rs_mem, rt_mem;
    logic lu, ebr, eld, hl, stall;

    md_busy_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (ex_md_start),
        .is_div  (ex_md_is_div),
        .md_busy (md_busy)
    );

    // $0 is never a producer, so matches against it are suppressed.
    assign rs_ex  = (ex_rd  != REG_ZERO) && (id_rs == ex_rd);
    assign rt_ex  = (ex_rd  != REG_ZERO) && (id_rt == ex_rd);
    assign rs_mem = (mem_rd != REG_ZERO) && (id_rs == mem_rd);
    assign rt_mem = (mem_rd != REG_ZERO) && (id_rt == mem_rd);

    assign lu    = ex_memrd & ex_wr & (((id_use_rs | id_early_rs) & rs_ex) |
                                       ((id_use_rt | id_early_rt) & rt_ex));
    assign ebr   = ex_wr & ((id_early_rs & rs_ex) | (id_early_rt & rt_ex));
    assign eld   = mem_memrd & ((id_early_rs & rs_mem) | (id_early_rt & rt_mem));
    assign hl    = id_hilo_use & (md_busy | ex_md_start);
    assign stall = lu | ebr | eld | hl;

    // A stalled branch is re-resolved next cycle, so its outcome is ignored now.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = id_br_taken;
        idex_flush = 1'b0;
        if (!reset) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end

endmodule
